// File: rtl/pulpemu_ctrl_regs.sv
// AXI4-Lite register window for controlling and observing the emulated PULPino SoC.
// Provides fetch enable, SoC reset release, synchronized end-of-computation status,
// eoc/cycle counters and a scratch register, all in the ps7_clk domain.
module pulpemu_ctrl_regs #(
  parameter int unsigned ADDR_WIDTH  = 11,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter logic [31:0] SCRATCH_RST = 32'h0000_0000
) (
  input  logic                    ps7_clk,
  input  logic                    ps7_rst_pulp_n,
  input  logic [ADDR_WIDTH-1:0]   s_awaddr,
  input  logic                    s_awvalid,
  output logic                    s_awready,
  input  logic [DATA_WIDTH-1:0]   s_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_wstrb,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  output logic [1:0]              s_bresp,
  output logic                    s_bvalid,
  input  logic                    s_bready,
  input  logic [ADDR_WIDTH-1:0]   s_araddr,
  input  logic                    s_arvalid,
  output logic                    s_arready,
  output logic [DATA_WIDTH-1:0]   s_rdata,
  output logic [1:0]              s_rresp,
  output logic                    s_rvalid,
  input  logic                    s_rready,
  input  logic                    eoc_i,
  input  logic [1:0]              return_i,
  output logic                    fetch_en_o,
  output logic                    soc_rst_n_o,
  output logic                    eoc_irq_o
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    REG_CTRL    = 3'd0,
    REG_STATUS  = 3'd1,
    REG_EOC_CNT = 3'd2,
    REG_CYC_CNT = 3'd3,
    REG_SCRATCH = 3'd4
  } reg_idx_e;

  // Mapped means upper address bits clear and word index within the five registers.
  function automatic logic addr_mapped(input logic [ADDR_WIDTH-1:0] addr);
    return (addr[ADDR_WIDTH-1:5] == '0) && (addr[4:2] <= 3'd4);
  endfunction

  // Write-channel holding state
  logic                  aw_hold, w_hold;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;

  // Register state
  logic                  irq_en_q;
  logic [31:0]           eoc_cnt_q, cyc_cnt_q, scratch_q;
  logic                  eoc_meta, eoc_sync, eoc_prev;
  logic [1:0]            ret_meta, ret_sync;

  logic                  aw_hs, w_hs, ar_hs, do_write, wr_ok;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_WIDTH-1:0] wr_strb;
  reg_idx_e              wr_idx;
  logic                  wr_ctrl, wr_eoc_cnt, wr_cyc_cnt, wr_scratch;
  logic [DATA_WIDTH-1:0] rd_val;
  logic                  rd_ok;
  logic                  unused_addr_lsbs;

  assign aw_hs = s_awvalid && s_awready;
  assign w_hs  = s_wvalid && s_wready;
  assign ar_hs = s_arvalid && s_arready;

  // A channel accepted this very cycle forwards its payload so AW+W together commit at once.
  assign wr_addr  = aw_hold ? aw_addr_q : s_awaddr;
  assign wr_data  = w_hold  ? wdata_q   : s_wdata;
  assign wr_strb  = w_hold  ? wstrb_q   : s_wstrb;
  assign do_write = (aw_hold || aw_hs) && (w_hold || w_hs) && !s_bvalid;
  assign wr_ok    = addr_mapped(wr_addr);
  assign wr_idx   = reg_idx_e'(wr_addr[4:2]);

  assign wr_ctrl    = do_write && wr_ok && (wr_idx == REG_CTRL);
  assign wr_eoc_cnt = do_write && wr_ok && (wr_idx == REG_EOC_CNT);
  assign wr_cyc_cnt = do_write && wr_ok && (wr_idx == REG_CYC_CNT);
  assign wr_scratch = do_write && wr_ok && (wr_idx == REG_SCRATCH);

  assign eoc_irq_o        = eoc_sync && irq_en_q;
  assign unused_addr_lsbs = ^{wr_addr[1:0], s_araddr[1:0]};

  // Write channel: capture AW and W independently, commit when both are present, then respond.
  always_ff @(posedge ps7_clk or negedge ps7_rst_pulp_n) begin
    if (!ps7_rst_pulp_n) begin
      s_awready <= 1'b1;
      s_wready  <= 1'b1;
      aw_hold   <= 1'b0;
      w_hold    <= 1'b0;
      aw_addr_q <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      s_bvalid  <= 1'b0;
      s_bresp   <= RESP_OKAY;
    end else begin
      // NOTE: non-blocking assignments; a later assignment in this block overrides an
      // earlier one, so the commit branch below deliberately cancels the hold flags.
      if (aw_hs) begin
        s_awready <= 1'b0;
        aw_hold   <= 1'b1;
        aw_addr_q <= s_awaddr;
      end
      if (w_hs) begin
        s_wready <= 1'b0;
        w_hold   <= 1'b1;
        wdata_q  <= s_wdata;
        wstrb_q  <= s_wstrb;
      end
      if (do_write) begin
        aw_hold  <= 1'b0;
        w_hold   <= 1'b0;
        s_bvalid <= 1'b1;
        s_bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (s_bvalid && s_bready) begin
        s_bvalid  <= 1'b0;
        s_awready <= 1'b1;
        s_wready  <= 1'b1;
      end
    end
  end

  // CTRL and SCRATCH are byte-strobed; CTRL only implements bits 31, 1 and 0.
  always_ff @(posedge ps7_clk or negedge ps7_rst_pulp_n) begin
    if (!ps7_rst_pulp_n) begin
      fetch_en_o  <= 1'b0;
      irq_en_q    <= 1'b0;
      soc_rst_n_o <= 1'b0;
      scratch_q   <= SCRATCH_RST;
    end else begin
      if (wr_ctrl && wr_strb[0]) begin
        fetch_en_o <= wr_data[0];
        irq_en_q   <= wr_data[1];
      end
      if (wr_ctrl && wr_strb[3]) soc_rst_n_o <= wr_data[31];
      for (int b = 0; b < 4; b++) begin
        if (wr_scratch && wr_strb[b]) scratch_q[8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Two-flop synchronizers for the SoC status lines plus a delayed copy for eoc edge detect.
  always_ff @(posedge ps7_clk or negedge ps7_rst_pulp_n) begin
    if (!ps7_rst_pulp_n) begin
      eoc_meta <= 1'b0;
      eoc_sync <= 1'b0;
      eoc_prev <= 1'b0;
      ret_meta <= 2'b00;
      ret_sync <= 2'b00;
    end else begin
      eoc_meta <= eoc_i;
      eoc_sync <= eoc_meta;
      eoc_prev <= eoc_sync;
      ret_meta <= return_i;
      ret_sync <= ret_meta;
    end
  end

  // Event counters; a software write clears regardless of strobes and wins over an increment.
  always_ff @(posedge ps7_clk or negedge ps7_rst_pulp_n) begin
    if (!ps7_rst_pulp_n) begin
      eoc_cnt_q <= '0;
      cyc_cnt_q <= '0;
    end else begin
      if (wr_eoc_cnt)                                        eoc_cnt_q <= '0;
      else if (eoc_sync && !eoc_prev && (eoc_cnt_q != '1))   eoc_cnt_q <= eoc_cnt_q + 32'd1;
      if (wr_cyc_cnt)                                        cyc_cnt_q <= '0;
      else if (fetch_en_o && soc_rst_n_o && !eoc_sync)       cyc_cnt_q <= cyc_cnt_q + 32'd1;
    end
  end

  // Read decode from current register values, so a same-cycle write is not yet visible.
  always_comb begin
    // NOTE: default first so every path assigns rd_val and no latch is inferred.
    rd_val = '0;
    rd_ok  = addr_mapped(s_araddr);
    if (rd_ok) begin
      case (reg_idx_e'(s_araddr[4:2]))
        REG_CTRL:    rd_val = {soc_rst_n_o, 29'b0, irq_en_q, fetch_en_o};
        REG_STATUS:  rd_val = {29'b0, ret_sync, eoc_sync};
        REG_EOC_CNT: rd_val = eoc_cnt_q;
        REG_CYC_CNT: rd_val = cyc_cnt_q;
        REG_SCRATCH: rd_val = scratch_q;
        default:     rd_val = '0;
      endcase
    end
  end

  // Read channel: register the response on AR handshake and hold it until R handshake.
  always_ff @(posedge ps7_clk or negedge ps7_rst_pulp_n) begin
    if (!ps7_rst_pulp_n) begin
      s_arready <= 1'b1;
      s_rvalid  <= 1'b0;
      s_rdata   <= '0;
      s_rresp   <= RESP_OKAY;
    end else if (ar_hs) begin
      s_arready <= 1'b0;
      s_rvalid  <= 1'b1;
      s_rdata   <= rd_val;
      s_rresp   <= rd_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (s_rvalid && s_rready) begin
      s_rvalid  <= 1'b0;
      s_arready <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pulpemu_ctrl_regs.sv
// Directed self-checking bench for pulpemu_ctrl_regs.
module tb_pulpemu_ctrl_regs;

  logic        ps7_clk = 1'b0;
  logic        ps7_rst_pulp_n = 1'b0;
  logic [10:0] s_awaddr = '0;
  logic        s_awvalid = 1'b0;
  logic        s_awready;
  logic [31:0] s_wdata = '0;
  logic [3:0]  s_wstrb = '0;
  logic        s_wvalid = 1'b0;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready = 1'b1;
  logic [10:0] s_araddr = '0;
  logic        s_arvalid = 1'b0;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready = 1'b1;
  logic        eoc_i = 1'b0;
  logic [1:0]  return_i = 2'b00;
  logic        fetch_en_o, soc_rst_n_o, eoc_irq_o;

  int checks = 0;
  int failures = 0;

  pulpemu_ctrl_regs #(
    .ADDR_WIDTH (11),
    .DATA_WIDTH (32),
    .SCRATCH_RST(32'h0000_0000)
  ) dut (
    .ps7_clk       (ps7_clk),
    .ps7_rst_pulp_n(ps7_rst_pulp_n),
    .s_awaddr      (s_awaddr),
    .s_awvalid     (s_awvalid),
    .s_awready     (s_awready),
    .s_wdata       (s_wdata),
    .s_wstrb       (s_wstrb),
    .s_wvalid      (s_wvalid),
    .s_wready      (s_wready),
    .s_bresp       (s_bresp),
    .s_bvalid      (s_bvalid),
    .s_bready      (s_bready),
    .s_araddr      (s_araddr),
    .s_arvalid     (s_arvalid),
    .s_arready     (s_arready),
    .s_rdata       (s_rdata),
    .s_rresp       (s_rresp),
    .s_rvalid      (s_rvalid),
    .s_rready      (s_rready),
    .eoc_i         (eoc_i),
    .return_i      (return_i),
    .fetch_en_o    (fetch_en_o),
    .soc_rst_n_o   (soc_rst_n_o),
    .eoc_irq_o     (eoc_irq_o)
  );

  always #5 ps7_clk = ~ps7_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic axi_write(input logic [10:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    int n;
    logic ah, wh, got;
    s_awaddr = addr; s_awvalid = 1'b1;
    s_wdata  = data; s_wstrb   = strb; s_wvalid = 1'b1;
    n = 0;
    while ((s_awvalid || s_wvalid) && n < 20) begin
      @(negedge ps7_clk);
      ah = s_awvalid && s_awready;
      wh = s_wvalid && s_wready;
      @(posedge ps7_clk); #1;
      if (ah) s_awvalid = 1'b0;
      if (wh) s_wvalid  = 1'b0;
      n++;
    end
    check("wr_accept", {31'b0, !(s_awvalid || s_wvalid)}, 32'd1);
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    resp = 2'b11; got = 1'b0; n = 0;
    while (!got && n < 20) begin
      @(negedge ps7_clk);
      if (s_bvalid) begin resp = s_bresp; got = 1'b1; end
      @(posedge ps7_clk); #1;
      n++;
    end
    check("wr_bresp_seen", {31'b0, got}, 32'd1);
  endtask

  task automatic axi_read(input logic [10:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    int n;
    logic ah, got;
    s_araddr = addr; s_arvalid = 1'b1;
    n = 0;
    while (s_arvalid && n < 20) begin
      @(negedge ps7_clk);
      ah = s_arready;
      @(posedge ps7_clk); #1;
      if (ah) s_arvalid = 1'b0;
      n++;
    end
    check("rd_accept", {31'b0, !s_arvalid}, 32'd1);
    s_arvalid = 1'b0;
    data = '0; resp = 2'b11; got = 1'b0; n = 0;
    while (!got && n < 20) begin
      @(negedge ps7_clk);
      if (s_rvalid) begin data = s_rdata; resp = s_rresp; got = 1'b1; end
      @(posedge ps7_clk); #1;
      n++;
    end
    check("rd_resp_seen", {31'b0, got}, 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    logic [1:0]  rr, br;

    // Reset state
    repeat (3) @(negedge ps7_clk);
    check("rst_awready", {31'b0, s_awready}, 32'd1);
    check("rst_wready",  {31'b0, s_wready},  32'd1);
    check("rst_arready", {31'b0, s_arready}, 32'd1);
    check("rst_bvalid",  {31'b0, s_bvalid},  32'd0);
    check("rst_rvalid",  {31'b0, s_rvalid},  32'd0);
    check("rst_fetch",   {31'b0, fetch_en_o},  32'd0);
    check("rst_socrst",  {31'b0, soc_rst_n_o}, 32'd0);
    check("rst_irq",     {31'b0, eoc_irq_o},   32'd0);
    ps7_rst_pulp_n = 1'b1;
    @(posedge ps7_clk); #1;
    axi_read(11'h000, rd, rr);
    check("rst_ctrl", rd, 32'h0);      check("rst_ctrl_resp", {30'b0, rr}, 32'd0);
    axi_read(11'h010, rd, rr);
    check("rst_scratch", rd, 32'h0);   check("rst_scratch_resp", {30'b0, rr}, 32'd0);

    // W before AW: W accepted now, AW three cycles later
    s_wdata = 32'h8000_0001; s_wstrb = 4'hF; s_wvalid = 1'b1;
    @(negedge ps7_clk); check("wfirst_wready", {31'b0, s_wready}, 32'd1);
    @(posedge ps7_clk); #1; s_wvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge ps7_clk);
      check("wfirst_wready_low", {31'b0, s_wready}, 32'd0);
      check("wfirst_no_bvalid",  {31'b0, s_bvalid}, 32'd0);
      check("wfirst_fetch_old",  {31'b0, fetch_en_o}, 32'd0);
      @(posedge ps7_clk); #1;
    end
    s_awaddr = 11'h000; s_awvalid = 1'b1;
    @(negedge ps7_clk);
    check("wfirst_aw_ready", {31'b0, s_awready}, 32'd1);
    check("wfirst_wready_c5", {31'b0, s_wready}, 32'd0);
    @(posedge ps7_clk); #1; s_awvalid = 1'b0;
    @(negedge ps7_clk);
    check("wfirst_bvalid",   {31'b0, s_bvalid},    32'd1);
    check("wfirst_bresp",    {30'b0, s_bresp},     32'd0);
    check("wfirst_wready_c6",{31'b0, s_wready},    32'd0);
    check("wfirst_awready_c6",{31'b0, s_awready},  32'd0);
    check("wfirst_fetch",    {31'b0, fetch_en_o},  32'd1);
    check("wfirst_socrst",   {31'b0, soc_rst_n_o}, 32'd1);
    @(posedge ps7_clk); #1;
    @(negedge ps7_clk);
    check("wfirst_b_done",   {31'b0, s_bvalid},  32'd0);
    check("wfirst_wready_back",  {31'b0, s_wready},  32'd1);
    check("wfirst_awready_back", {31'b0, s_awready}, 32'd1);
    @(posedge ps7_clk); #1;
    axi_read(11'h000, rd, rr);
    check("ctrl_readback", rd, 32'h8000_0001);

    // SCRATCH byte strobes
    axi_write(11'h010, 32'hAABB_CCDD, 4'b0101, br);
    check("scr_bresp", {30'b0, br}, 32'd0);
    axi_read(11'h010, rd, rr);
    check("scr_strb_0101", rd, 32'h00BB_00DD);
    axi_write(11'h010, 32'hFFFF_FFFF, 4'b1000, br);
    axi_read(11'h010, rd, rr);
    check("scr_strb_1000", rd, 32'hFFBB_00DD);

    // Read and write of SCRATCH in the same cycle returns the pre-write value
    s_awaddr = 11'h010; s_wdata = 32'h1234_5678; s_wstrb = 4'hF;
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_araddr = 11'h010; s_arvalid = 1'b1;
    @(posedge ps7_clk); #1;
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    @(negedge ps7_clk);
    check("rw_same_rvalid", {31'b0, s_rvalid}, 32'd1);
    check("rw_same_bvalid", {31'b0, s_bvalid}, 32'd1);
    check("rw_same_old", s_rdata, 32'hFFBB_00DD);
    @(posedge ps7_clk); #1;
    axi_read(11'h010, rd, rr);
    check("rw_same_new", rd, 32'h1234_5678);

    // Unmapped and read-only accesses
    axi_read(11'h040, rd, rr);
    check("unmap_rd_data", rd, 32'h0);  check("unmap_rd_resp", {30'b0, rr}, 32'd2);
    axi_read(11'h014, rd, rr);
    check("hole_rd_resp", {30'b0, rr}, 32'd2);
    axi_write(11'h018, 32'hDEAD_BEEF, 4'hF, br);
    check("hole_wr_resp", {30'b0, br}, 32'd2);
    axi_write(11'h030, 32'hCAFE_F00D, 4'hF, br);
    check("upper_wr_resp", {30'b0, br}, 32'd2);
    axi_write(11'h004, 32'hFFFF_FFFF, 4'hF, br);
    check("status_wr_resp", {30'b0, br}, 32'd0);
    axi_read(11'h010, rd, rr);
    check("scr_untouched", rd, 32'h1234_5678);
    axi_read(11'h004, rd, rr);
    check("status_idle", rd, 32'h0);    check("status_resp", {30'b0, rr}, 32'd0);

    // CYC_CNT clear coinciding with an increment, read back on the very next cycle
    axi_read(11'h00C, rd, rr);
    check("cyc_running", {31'b0, rd != 32'h0}, 32'd1);
    s_awaddr = 11'h00C; s_wdata = 32'hFFFF_FFFF; s_wstrb = 4'h0;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    @(posedge ps7_clk); #1;
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    s_araddr = 11'h00C; s_arvalid = 1'b1;
    @(posedge ps7_clk); #1;
    s_arvalid = 1'b0;
    @(negedge ps7_clk);
    check("cyc_clear_rvalid", {31'b0, s_rvalid}, 32'd1);
    check("cyc_clear_zero", s_rdata, 32'h0);
    @(posedge ps7_clk); #1;

    // Stalled read of the running counter: response frozen, arready low
    s_rready = 1'b0; s_araddr = 11'h00C; s_arvalid = 1'b1;
    @(posedge ps7_clk); #1; s_arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge ps7_clk);
      check("stall_rvalid",  {31'b0, s_rvalid},  32'd1);
      check("stall_arready", {31'b0, s_arready}, 32'd0);
      check("stall_rdata",   s_rdata, 32'd2);
    end
    s_rready = 1'b1;
    @(posedge ps7_clk); #1;
    @(negedge ps7_clk);
    check("stall_released_rvalid",  {31'b0, s_rvalid},  32'd0);
    check("stall_released_arready", {31'b0, s_arready}, 32'd1);
    @(posedge ps7_clk); #1;

    // CYC_CNT over ~100 cycles, stopped by eoc
    axi_write(11'h00C, 32'h0, 4'hF, br);
    repeat (97) @(posedge ps7_clk);
    #1; eoc_i = 1'b1;
    repeat (6) @(posedge ps7_clk);
    #1;
    axi_read(11'h00C, rd, rr);
    check("cyc_100", {31'b0, (rd >= 32'd98) && (rd <= 32'd102)}, 32'd1);
    repeat (5) @(posedge ps7_clk);
    #1;
    axi_read(11'h00C, rd, rr);
    check("cyc_stopped", {31'b0, (rd >= 32'd98) && (rd <= 32'd102)}, 32'd1);

    // EOC counting and interrupt
    eoc_i = 1'b0;
    repeat (5) @(posedge ps7_clk);
    #1;
    axi_write(11'h000, 32'h8000_0003, 4'hF, br);
    axi_write(11'h008, 32'h1234_5678, 4'h0, br);
    axi_read(11'h008, rd, rr);
    check("eoc_cnt_cleared", rd, 32'h0);
    return_i = 2'b10;
    for (int i = 0; i < 3; i++) begin
      eoc_i = 1'b1;
      @(negedge ps7_clk); check("irq_lag0", {31'b0, eoc_irq_o}, 32'd0);
      @(negedge ps7_clk); check("irq_lag1", {31'b0, eoc_irq_o}, 32'd0);
      @(negedge ps7_clk); check("irq_high", {31'b0, eoc_irq_o}, 32'd1);
      @(posedge ps7_clk); #1;
      axi_read(11'h004, rd, rr);
      check("status_eoc", rd, 32'h5);
      eoc_i = 1'b0;
      @(negedge ps7_clk); check("irq_hold0", {31'b0, eoc_irq_o}, 32'd1);
      @(negedge ps7_clk); check("irq_hold1", {31'b0, eoc_irq_o}, 32'd1);
      @(negedge ps7_clk); check("irq_low",   {31'b0, eoc_irq_o}, 32'd0);
      repeat (4) @(posedge ps7_clk);
      #1;
    end
    axi_read(11'h008, rd, rr);
    check("eoc_cnt_3", rd, 32'd3);
    axi_read(11'h004, rd, rr);
    check("status_ret_only", rd, 32'h4);

    // CTRL low-byte strobe clears fetch_en and IRQ_EN, leaves soc_rst_n
    axi_write(11'h000, 32'h0000_0000, 4'b0001, br);
    axi_read(11'h000, rd, rr);
    check("ctrl_strb", rd, 32'h8000_0000);
    check("ctrl_strb_fetch", {31'b0, fetch_en_o}, 32'd0);
    eoc_i = 1'b1;
    repeat (4) @(posedge ps7_clk);
    #1;
    check("irq_masked", {31'b0, eoc_irq_o}, 32'd0);

    // Asynchronous reset during a pending read response
    s_rready = 1'b0; s_araddr = 11'h010; s_arvalid = 1'b1;
    @(posedge ps7_clk); #1; s_arvalid = 1'b0;
    @(negedge ps7_clk);
    check("prerst_rvalid", {31'b0, s_rvalid}, 32'd1);
    #2; ps7_rst_pulp_n = 1'b0;
    #1;
    check("midrst_rvalid",  {31'b0, s_rvalid},    32'd0);
    check("midrst_arready", {31'b0, s_arready},   32'd1);
    check("midrst_socrst",  {31'b0, soc_rst_n_o}, 32'd0);
    s_rready = 1'b1;
    @(negedge ps7_clk); ps7_rst_pulp_n = 1'b1;
    @(posedge ps7_clk); #1;
    axi_read(11'h010, rd, rr);
    check("postrst_scratch", rd, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
